// File: rtl/seg_pkg.sv
// seg_pkg: shared constants for the seg_scan display driver.
// Holds the blank pattern, the hex decode table and the drive polarities.
package seg_pkg;

  localparam logic [6:0] SEG_BLANK = 7'h7F;

  localparam logic AN_ON  = 1'b0;
  localparam logic AN_OFF = 1'b1;
  localparam logic DP_ON  = 1'b0;
  localparam logic DP_OFF = 1'b1;

  // {g,f,e,d,c,b,a}, active-low, indexed by nibble
  localparam logic [6:0] SEG_TABLE [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30,
    7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03,
    7'h46, 7'h21, 7'h06, 7'h0E
  };

endpackage

// File: rtl/seg_scan_if.sv
// seg_scan_if: value load bus in, scanned display drive out.
// master drives load/value/dp_in; slave drives an/seg/dp/frame_tick.
interface seg_scan_if #(
  parameter int DIGITS = 4
);

  logic                  load;
  logic [4*DIGITS-1:0]   value;
  logic [DIGITS-1:0]     dp_in;
  logic [DIGITS-1:0]     an;
  logic [6:0]            seg;
  logic                  dp;
  logic                  frame_tick;

  modport master (
    output load, value, dp_in,
    input  an, seg, dp, frame_tick
  );

  modport slave (
    input  load, value, dp_in,
    output an, seg, dp, frame_tick
  );

endinterface

// File: rtl/seg_scan_hex_to_seg.sv
// hex_to_seg: combinational nibble to active-low 7-segment decoder.
// Ports: nib (4-bit hex in), seg ({g,f,e,d,c,b,a} active-low out).
module hex_to_seg
  import seg_pkg::*;
(
  input  logic [3:0] nib,
  output logic [6:0] seg
);

  assign seg = SEG_TABLE[nib];

endmodule

// File: rtl/seg_scan.sv
// seg_scan: double-buffered multiplexed common-anode hex display driver.
// Ports: clk, rst (sync active-high), bus (seg_scan_if.slave):
//   load/value/dp_in in; an/seg/dp/frame_tick out.
// Option: define SEG_SCAN_LZ_BLANK_EN for leading-zero blanking.
module seg_scan
  import seg_pkg::*;
#(
  parameter int DIGITS   = 4,
  parameter int SCAN_DIV = 100000
) (
  input  logic       clk,
  input  logic       rst,
  seg_scan_if.slave  bus
);

  localparam int DW = $clog2(SCAN_DIV);
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int VW = 4 * DIGITS;

  localparam logic [DW-1:0] DIV_LAST = DW'(SCAN_DIV - 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(DIGITS - 1);

  logic [DW-1:0]     div_q, div_d;
  logic [IW-1:0]     idx_q, idx_d;
  logic [VW-1:0]     shadow_q, shadow_d;
  logic [DIGITS-1:0] shadow_dp_q, shadow_dp_d;
  logic [VW-1:0]     disp_q, disp_d;
  logic [DIGITS-1:0] disp_dp_q, disp_dp_d;
  logic              pend_q, pend_d;
  logic [DIGITS-1:0] an_q, an_d;
  logic [6:0]        seg_q, seg_d;
  logic              dp_q, dp_d;
  logic              tick_q, tick_d;

  logic              slot_end;
  logic              wrap;
  logic [3:0]        nib;
  logic              nib_dp;
  logic [6:0]        seg_raw;
  logic              blank;

  always_comb begin
    slot_end    = (div_q == DIV_LAST);
    wrap        = slot_end && (idx_q == IDX_LAST);
    div_d       = slot_end ? '0 : div_q + DW'(1);
    idx_d       = idx_q;
    if (slot_end) begin
      idx_d     = wrap ? '0 : idx_q + IW'(1);
    end
    tick_d      = wrap;
    shadow_d    = shadow_q;
    shadow_dp_d = shadow_dp_q;
    disp_d      = disp_q;
    disp_dp_d   = disp_dp_q;
    pend_d      = pend_q;
    if (bus.load) begin
      shadow_d    = bus.value;
      shadow_dp_d = bus.dp_in;
      pend_d      = 1'b1;
    end
    // a load landing on the boundary bypasses the shadow
    if (wrap) begin
      pend_d = 1'b0;
      if (bus.load) begin
        disp_d    = bus.value;
        disp_dp_d = bus.dp_in;
      end else if (pend_q) begin
        disp_d    = shadow_q;
        disp_dp_d = shadow_dp_q;
      end
    end
  end

  always_comb begin
    nib    = '0;
    nib_dp = 1'b0;
    an_d   = '1;
    for (int i = 0; i < DIGITS; i++) begin
      if (idx_q == IW'(i)) begin
        nib     = disp_q[4*i +: 4];
        nib_dp  = disp_dp_q[i];
        an_d[i] = AN_ON;
      end else begin
        an_d[i] = AN_OFF;
      end
    end
  end

  hex_to_seg u_dec (
    .nib (nib),
    .seg (seg_raw)
  );

`ifdef SEG_SCAN_LZ_BLANK_EN
  logic [DIGITS-1:0] lz;

  // lz[i]: nibble i and every higher nibble are zero
  always_comb begin
    lz = '0;
    lz[DIGITS-1] = (disp_q[VW-1 -: 4] == 4'h0);
    for (int i = DIGITS - 2; i >= 0; i--) begin
      lz[i] = lz[i+1] && (disp_q[4*i +: 4] == 4'h0);
    end
  end

  always_comb begin
    blank = 1'b0;
    for (int i = 1; i < DIGITS; i++) begin
      if (idx_q == IW'(i)) begin
        blank = lz[i];
      end
    end
  end
`else
  assign blank = 1'b0;
`endif

  always_comb begin
    seg_d = blank ? SEG_BLANK : seg_raw;
    dp_d  = nib_dp ? DP_ON : DP_OFF;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      div_q       <= '0;
      idx_q       <= '0;
      shadow_q    <= '0;
      shadow_dp_q <= '0;
      disp_q      <= '0;
      disp_dp_q   <= '0;
      pend_q      <= 1'b0;
      an_q        <= '1;
      seg_q       <= SEG_BLANK;
      dp_q        <= DP_OFF;
      tick_q      <= 1'b0;
    end else begin
      div_q       <= div_d;
      idx_q       <= idx_d;
      shadow_q    <= shadow_d;
      shadow_dp_q <= shadow_dp_d;
      disp_q      <= disp_d;
      disp_dp_q   <= disp_dp_d;
      pend_q      <= pend_d;
      an_q        <= an_d;
      seg_q       <= seg_d;
      dp_q        <= dp_d;
      tick_q      <= tick_d;
    end
  end

  assign bus.an         = an_q;
  assign bus.seg        = seg_q;
  assign bus.dp         = dp_q;
  assign bus.frame_tick = tick_q;

endmodule

// File: tb/tb_seg_scan.sv
// tb_seg_scan: directed + random checks of seg_scan against a
// frame-level reference model (cycle count -> digit, latched frame value).
module tb_seg_scan;

  localparam int D = 4;
  localparam int S = 4;
  localparam int F = D * S;

  logic clk = 1'b0;
  logic rst;

  seg_scan_if #(.DIGITS(D)) bus ();

  seg_scan #(.DIGITS(D), .SCAN_DIV(S)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;
  int e;

  logic [4*D-1:0] frame_v;
  logic [D-1:0]   frame_dp;
  logic [4*D-1:0] next_v;
  logic [D-1:0]   next_dp;
  bit             has_next;

  logic [6:0] tbl [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

  function automatic logic [6:0] exp_seg(int d);
`ifdef SEG_SCAN_LZ_BLANK_EN
    if (d > 0 && (frame_v >> (4 * d)) == 0) return 7'h7F;
`endif
    return tbl[frame_v[4*d +: 4]];
  endfunction

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp_v);
    n_assert++;
    assert (obs === exp_v) else begin
      n_fail++;
      $error("FAIL %s at cycle %0d: got %0h expected %0h",
             tag, e, obs, exp_v);
    end
  endtask

  task automatic check_reset();
    chk("rst_an",   32'(bus.an),         32'hF);
    chk("rst_seg",  32'(bus.seg),        32'h7F);
    chk("rst_dp",   32'(bus.dp),         32'h1);
    chk("rst_tick", 32'(bus.frame_tick), 32'h0);
  endtask

  task automatic do_reset(int n);
    rst = 1'b1;
    bus.load = 1'b0;
    repeat (n) begin
      @(posedge clk);
      @(negedge clk);
      check_reset();
    end
    rst = 1'b0;
    e = 0;
    frame_v  = '0;
    frame_dp = '0;
    has_next = 1'b0;
    check_reset();
  endtask

  // one clock: drive, model the edge, check outputs at the negedge
  task automatic step(bit ld, logic [15:0] v, logic [3:0] dpi);
    int         d;
    logic [3:0] ean;
    logic [6:0] eseg;
    logic       edp;
    logic       etick;
    bus.load  = ld;
    bus.value = v;
    bus.dp_in = dpi;
    @(posedge clk);
    e++;
    d     = ((e - 1) / S) % D;
    ean   = ~(4'(1) << d);
    eseg  = exp_seg(d);
    edp   = ~frame_dp[d];
    etick = (e % F == 0);
    if (e % F == 0) begin
      if (ld) begin
        frame_v  = v;
        frame_dp = dpi;
      end else if (has_next) begin
        frame_v  = next_v;
        frame_dp = next_dp;
      end
      has_next = 1'b0;
    end else if (ld) begin
      next_v   = v;
      next_dp  = dpi;
      has_next = 1'b1;
    end
    @(negedge clk);
    bus.load = 1'b0;
    chk("an",   32'(bus.an),         32'(ean));
    chk("seg",  32'(bus.seg),        32'(eseg));
    chk("dp",   32'(bus.dp),         32'(edp));
    chk("tick", 32'(bus.frame_tick), 32'(etick));
  endtask

  task automatic idle(int n);
    repeat (n) step(1'b0, 16'($urandom), 4'($urandom));
  endtask

  // park just before an edge that is a frame boundary
  task automatic to_boundary();
    while ((e + 1) % F != 0) idle(1);
  endtask

  initial begin
    rst       = 1'b1;
    bus.load  = 1'b0;
    bus.value = '0;
    bus.dp_in = '0;
    e         = 0;
    @(negedge clk);
    do_reset(3);

    step(1'b1, 16'h1234, 4'h0);
    idle(2 * F + 3);

    step(1'b1, 16'h5555, 4'h0);
    to_boundary();
    idle(6);
    step(1'b1, 16'hAAAA, 4'h0);
    idle(F + 8);

    step(1'b1, 16'h0123, 4'h0);
    to_boundary();
    step(1'b1, 16'hF00D, 4'h0);
    idle(2 * F);

    step(1'b1, 16'h0070, 4'b0100);
    idle(2 * F + 2);

    step(1'b1, 16'h0000, 4'b1111);
    idle(2 * F);

    step(1'b1, 16'hBEEF, 4'b1001);
    idle(5);
    do_reset(2);
    idle(F + 4);

    for (int i = 0; i < 900; i++) begin
      if ($urandom_range(0, 299) == 0) begin
        do_reset(1);
      end else begin
        step($urandom_range(0, 9) == 0,
             ($urandom_range(0, 3) == 0) ? 16'($urandom_range(0, 255))
                                         : 16'($urandom),
             4'($urandom));
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

endmodule
